// File: rtl/mvd_cost_sel.sv
// rtl/mvd_cost_sel.sv - serial MVP candidate MVD cost evaluator with best-candidate select
module mvd_cost_sel #(
  parameter int FMV_W   = 10,
  parameter int MVD_W   = 11,
  parameter int NUM_MVP = 2,
  parameter int IDX_W   = 3
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start_i,
  input  logic [2*FMV_W-1:0]   mv_i,
  output logic                 busy_o,
  input  logic                 mvp_valid_i,
  output logic                 mvp_ready_o,
  input  logic [2*FMV_W-1:0]   mvp_i,
  output logic                 done_o,
  output logic [IDX_W-1:0]     best_idx_o,
  output logic [2*MVD_W-1:0]   best_mvd_o,
  output logic [7:0]           best_bits_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CAND  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int MVD_MAX = (1 << (MVD_W - 1)) - 1;
  localparam int MVD_MIN = -(1 << (MVD_W - 1));
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MVP - 1);

  // Control state
  logic [1:0]          state_q, state_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [2*FMV_W-1:0]  mv_q, mv_d;
  // Stage 1: clipped differences
  logic                s1_vld_q, s1_vld_d;
  logic [IDX_W-1:0]    s1_idx_q, s1_idx_d;
  logic [MVD_W-1:0]    s1_dx_q, s1_dx_d, s1_dy_q, s1_dy_d;
  // Stage 2: bit cost
  logic                s2_vld_q, s2_vld_d;
  logic [IDX_W-1:0]    s2_idx_q, s2_idx_d;
  logic [MVD_W-1:0]    s2_dx_q, s2_dx_d, s2_dy_q, s2_dy_d;
  logic [7:0]          s2_bits_q, s2_bits_d;
  // Running best of the current evaluation
  logic [IDX_W-1:0]    run_idx_q, run_idx_d;
  logic [MVD_W-1:0]    run_dx_q, run_dx_d, run_dy_q, run_dy_d;
  logic [7:0]          run_bits_q, run_bits_d;
  // Published result
  logic                done_q, done_d;
  logic [IDX_W-1:0]    out_idx_q, out_idx_d;
  logic [2*MVD_W-1:0]  out_mvd_q, out_mvd_d;
  logic [7:0]          out_bits_q, out_bits_d;

  logic accept_start;
  logic cand_acc;

  // Signed difference at FMV_W+1 bits, saturated into the MVD range
  function automatic logic [MVD_W-1:0] sat_diff(input logic [FMV_W-1:0] a,
                                                input logic [FMV_W-1:0] b);
    logic signed [FMV_W:0] d;
    int                    di;
    logic [MVD_W-1:0]      r;
    d  = $signed({a[FMV_W-1], a}) - $signed({b[FMV_W-1], b});
    di = int'(d);
    if (di > MVD_MAX)      r = MVD_MAX[MVD_W-1:0];
    else if (di < MVD_MIN) r = MVD_MIN[MVD_W-1:0];
    else                   r = di[MVD_W-1:0];
    return r;
  endfunction

  // Exp-Golomb-style length of one component: 1 for zero, else 2*msb(|d|)+3
  function automatic logic [7:0] comp_cost(input logic [MVD_W-1:0] d);
    logic [MVD_W-1:0] a;
    logic [7:0]       c;
    // The most negative value maps to 2^(MVD_W-1), which fits unsigned
    a = d[MVD_W-1] ? (~d + 1'b1) : d;
    c = 8'd1;
    for (int i = 0; i < MVD_W; i++) begin
      if (a[i]) c = 8'(2 * i + 3);
    end
    return c;
  endfunction

  assign mvp_ready_o  = (state_q == ST_CAND);
  assign busy_o       = (state_q != ST_IDLE);
  assign cand_acc     = mvp_ready_o && mvp_valid_i;
  // A start landing in the done cycle is dropped so results are never overwritten early
  assign accept_start = (state_q == ST_IDLE) && start_i && !done_q;

  // Next-state logic: FSM, candidate pipeline, running best and output capture
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mv_d       = mv_q;
    done_d     = 1'b0;
    out_idx_d  = out_idx_q;
    out_mvd_d  = out_mvd_q;
    out_bits_d = out_bits_q;
    run_idx_d  = run_idx_q;
    run_dx_d   = run_dx_q;
    run_dy_d   = run_dy_q;
    run_bits_d = run_bits_q;

    // Stage 1 loads every cycle; the valid bit decides whether it counts
    s1_vld_d = cand_acc;
    s1_idx_d = cnt_q;
    s1_dx_d  = sat_diff(mv_q[FMV_W-1:0], mvp_i[FMV_W-1:0]);
    s1_dy_d  = sat_diff(mv_q[2*FMV_W-1:FMV_W], mvp_i[2*FMV_W-1:FMV_W]);

    s2_vld_d  = s1_vld_q;
    s2_idx_d  = s1_idx_q;
    s2_dx_d   = s1_dx_q;
    s2_dy_d   = s1_dy_q;
    s2_bits_d = comp_cost(s1_dx_q) + comp_cost(s1_dy_q);

    // Strict less-than keeps the earlier candidate on a tie
    if (s2_vld_q && (s2_bits_q < run_bits_q)) begin
      run_idx_d  = s2_idx_q;
      run_dx_d   = s2_dx_q;
      run_dy_d   = s2_dy_q;
      run_bits_d = s2_bits_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_start) begin
          mv_d       = mv_i;
          cnt_d      = '0;
          run_idx_d  = '0;
          run_bits_d = 8'hFF;
          state_d    = ST_CAND;
        end
      end
      ST_CAND: begin
        if (cand_acc) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!s1_vld_q && !s2_vld_q) begin
          done_d     = 1'b1;
          out_idx_d  = run_idx_q;
          out_mvd_d  = {run_dy_q, run_dx_q};
          out_bits_d = run_bits_q;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any evaluation in flight without a done pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mv_q       <= '0;
      s1_vld_q   <= 1'b0;
      s1_idx_q   <= '0;
      s1_dx_q    <= '0;
      s1_dy_q    <= '0;
      s2_vld_q   <= 1'b0;
      s2_idx_q   <= '0;
      s2_dx_q    <= '0;
      s2_dy_q    <= '0;
      s2_bits_q  <= '0;
      run_idx_q  <= '0;
      run_dx_q   <= '0;
      run_dy_q   <= '0;
      run_bits_q <= 8'hFF;
      done_q     <= 1'b0;
      out_idx_q  <= '0;
      out_mvd_q  <= '0;
      out_bits_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mv_q       <= mv_d;
      s1_vld_q   <= s1_vld_d;
      s1_idx_q   <= s1_idx_d;
      s1_dx_q    <= s1_dx_d;
      s1_dy_q    <= s1_dy_d;
      s2_vld_q   <= s2_vld_d;
      s2_idx_q   <= s2_idx_d;
      s2_dx_q    <= s2_dx_d;
      s2_dy_q    <= s2_dy_d;
      s2_bits_q  <= s2_bits_d;
      run_idx_q  <= run_idx_d;
      run_dx_q   <= run_dx_d;
      run_dy_q   <= run_dy_d;
      run_bits_q <= run_bits_d;
      done_q     <= done_d;
      out_idx_q  <= out_idx_d;
      out_mvd_q  <= out_mvd_d;
      out_bits_q <= out_bits_d;
    end
  end

  assign done_o      = done_q;
  assign best_idx_o  = out_idx_q;
  assign best_mvd_o  = out_mvd_q;
  assign best_bits_o = out_bits_q;

endmodule

// File: tb/tb_mvd_cost_sel.sv
// tb/tb_mvd_cost_sel.sv - scoreboard bench for mvd_cost_sel (2-candidate and 8-candidate configs)
module tb_mvd_cost_sel;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;

  // Instance A: defaults (MVD_W=11, NUM_MVP=2)
  logic        a_start, a_valid, a_busy, a_ready, a_done;
  logic [19:0] a_mv, a_mvp;
  logic [2:0]  a_idx;
  logic [21:0] a_mvd;
  logic [7:0]  a_bits;

  // Instance B: MVD_W=10 (saturating), NUM_MVP=8
  logic        b_start, b_valid, b_busy, b_ready, b_done;
  logic [19:0] b_mv, b_mvp;
  logic [2:0]  b_idx;
  logic [19:0] b_mvd;
  logic [7:0]  b_bits;

  mvd_cost_sel u_a (
    .clk(clk), .rstn(rstn), .start_i(a_start), .mv_i(a_mv), .busy_o(a_busy),
    .mvp_valid_i(a_valid), .mvp_ready_o(a_ready), .mvp_i(a_mvp), .done_o(a_done),
    .best_idx_o(a_idx), .best_mvd_o(a_mvd), .best_bits_o(a_bits)
  );

  mvd_cost_sel #(.FMV_W(10), .MVD_W(10), .NUM_MVP(8), .IDX_W(3)) u_b (
    .clk(clk), .rstn(rstn), .start_i(b_start), .mv_i(b_mv), .busy_o(b_busy),
    .mvp_valid_i(b_valid), .mvp_ready_o(b_ready), .mvp_i(b_mvp), .done_o(b_done),
    .best_idx_o(b_idx), .best_mvd_o(b_mvd), .best_bits_o(b_bits)
  );

  typedef struct {
    int idx;
    int mx;
    int my;
    int bits;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb, e;
  int   errors = 0;
  int   checks = 0;
  int   cand_x[8];
  int   cand_y[8];

  task automatic check(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  function automatic logic [19:0] pk(input int x, input int y);
    logic [9:0] xs, ys;
    xs = x[9:0];
    ys = y[9:0];
    return {ys, xs};
  endfunction

  function automatic int clipd(input int d, input int w);
    int hi, lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (d > hi) return hi;
    if (d < lo) return lo;
    return d;
  endfunction

  function automatic int ccost(input int d);
    int a, n;
    a = (d < 0) ? -d : d;
    if (a == 0) return 1;
    n = 0;
    while (a > 1) begin
      a = a >> 1;
      n++;
    end
    return 2 * n + 3;
  endfunction

  function automatic exp_t model(input int u, input int mx, input int my);
    exp_t r;
    int w, n, dx, dy, c;
    w = (u == 0) ? 11 : 10;
    n = (u == 0) ? 2 : 8;
    r.bits = 1000;
    r.idx = 0; r.mx = 0; r.my = 0;
    for (int i = 0; i < n; i++) begin
      dx = clipd(mx - cand_x[i], w);
      dy = clipd(my - cand_y[i], w);
      c  = ccost(dx) + ccost(dy);
      if (c < r.bits) begin
        r.bits = c; r.idx = i; r.mx = dx; r.my = dy;
      end
    end
    return r;
  endfunction

  task automatic setc(input int i, input int x, input int y);
    cand_x[i] = x;
    cand_y[i] = y;
  endtask

  task automatic set_start(input int u, input logic v, input logic [19:0] mv);
    if (u == 0) begin a_start = v; a_mv = mv; end
    else        begin b_start = v; b_mv = mv; end
  endtask

  task automatic set_mvp(input int u, input logic v, input logic [19:0] p);
    if (u == 0) begin a_valid = v; a_mvp = p; end
    else        begin b_valid = v; b_mvp = p; end
  endtask

  function automatic logic get_ready(input int u);
    return (u == 0) ? a_ready : b_ready;
  endfunction

  function automatic logic get_done(input int u);
    return (u == 0) ? a_done : b_done;
  endfunction

  function automatic logic get_busy(input int u);
    return (u == 0) ? a_busy : b_busy;
  endfunction

  // One evaluation: push expectation, start, feed candidates, check done latency
  task automatic run_eval(input int u, input int mx, input int my, input exp_t ex,
                          input int gap_mode, input bit extra_start);
    int n, g, k;
    logic r;
    n = (u == 0) ? 2 : 8;
    if (u == 0) qa.push_back(ex); else qb.push_back(ex);
    @(posedge clk); #1 set_start(u, 1'b1, pk(mx, my));
    @(posedge clk); #1 set_start(u, 1'b0, pk(0, 0));
    for (int i = 0; i < n; i++) begin
      g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? (i % 4) : int'($urandom_range(0, 3));
      repeat (g) begin
        if (extra_start && i == 2) set_start(u, 1'b1, pk(-300, 200));
        @(posedge clk); #1 set_start(u, 1'b0, pk(0, 0));
      end
      set_mvp(u, 1'b1, pk(cand_x[i], cand_y[i]));
      k = 0;
      do begin
        @(negedge clk); r = get_ready(u);
        @(posedge clk); k++;
      end while (!r && k < 50);
      if (!r) check("accept_timeout", 0, 1);
      #1 set_mvp(u, 1'b0, '0);
    end
    k = 0;
    @(negedge clk);
    while (!get_done(u) && k < 8) begin
      @(negedge clk);
      k++;
    end
    check((u == 0) ? "a_done_latency" : "b_done_latency", k, 3);
    check((u == 0) ? "a_busy_in_done" : "b_busy_in_done", int'(get_busy(u)), 0);
  endtask

  // Scoreboard monitors: compare whenever a result is presented
  always @(negedge clk) begin
    if (a_done) begin
      if (qa.size() == 0) check("a_spurious_done", 1, 0);
      else begin
        ea = qa.pop_front();
        check("a_idx", int'(a_idx), ea.idx);
        check("a_mvd_x", int'($signed(a_mvd[10:0])), ea.mx);
        check("a_mvd_y", int'($signed(a_mvd[21:11])), ea.my);
        check("a_bits", int'(a_bits), ea.bits);
      end
    end
  end

  always @(negedge clk) begin
    if (b_done) begin
      if (qb.size() == 0) check("b_spurious_done", 1, 0);
      else begin
        eb = qb.pop_front();
        check("b_idx", int'(b_idx), eb.idx);
        check("b_mvd_x", int'($signed(b_mvd[9:0])), eb.mx);
        check("b_mvd_y", int'($signed(b_mvd[19:10])), eb.my);
        check("b_bits", int'(b_bits), eb.bits);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int mx, my;
    rstn = 1'b0;
    a_start = 1'b0; a_valid = 1'b0; a_mv = '0; a_mvp = '0;
    b_start = 1'b0; b_valid = 1'b0; b_mv = '0; b_mvp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("a_rst_busy", int'(a_busy), 0);
    check("a_rst_ready", int'(a_ready), 0);
    check("a_rst_done", int'(a_done), 0);
    check("a_rst_idx", int'(a_idx), 0);
    check("a_rst_mvd", int'(a_mvd), 0);
    check("a_rst_bits", int'(a_bits), 0);
    check("b_rst_busy", int'(b_busy), 0);
    check("b_rst_ready", int'(b_ready), 0);
    check("b_rst_done", int'(b_done), 0);
    check("b_rst_idx", int'(b_idx), 0);
    check("b_rst_mvd", int'(b_mvd), 0);
    check("b_rst_bits", int'(b_bits), 0);
    @(posedge clk); #1 rstn = 1'b1;

    // Basic selection: candidate 1 is exact
    setc(0, 4, -3); setc(1, 5, -3);
    e = '{1, 0, 0, 2};
    run_eval(0, 5, -3, e, 0, 1'b0);

    // Tie: both cost 4, earlier index wins, mvd x = -1
    setc(0, 1, 0); setc(1, -1, 0);
    e = '{0, -1, 0, 4};
    run_eval(0, 0, 0, e, 0, 1'b0);

    // Positive saturation: 1023 clips to 511, cost 19+1
    for (int i = 0; i < 8; i++) setc(i, -512, 300);
    setc(3, -512, 0);
    e = '{3, 511, 0, 20};
    run_eval(1, 511, 0, e, 0, 1'b0);

    // Negative saturation: -1023 clips to -512, cost 21+1
    for (int i = 0; i < 8; i++) setc(i, 511, -300);
    setc(5, 511, 0);
    e = '{5, -512, 0, 22};
    run_eval(1, -512, 0, e, 0, 1'b0);

    // Gaps on valid plus a stray start while busy; tie between idx 2 and 6
    setc(0, 0, 0);     setc(1, 8, -20);  setc(2, 11, -20); setc(3, 10, -16);
    setc(4, 9, -21);   setc(5, 12, -20); setc(6, 10, -19); setc(7, 100, 100);
    e = '{2, -1, 0, 4};
    run_eval(1, 10, -20, e, 1, 1'b1);

    // Reset after one of two candidates: abort, outputs clear, no done
    @(posedge clk); #1 set_start(0, 1'b1, pk(7, 7));
    @(posedge clk); #1 set_start(0, 1'b0, pk(0, 0)); set_mvp(0, 1'b1, pk(1, 1));
    @(posedge clk); #1 set_mvp(0, 1'b0, '0); rstn = 1'b0;
    @(negedge clk);
    check("a_midrst_busy", int'(a_busy), 0);
    check("a_midrst_ready", int'(a_ready), 0);
    check("a_midrst_done", int'(a_done), 0);
    check("a_midrst_idx", int'(a_idx), 0);
    check("a_midrst_mvd", int'(a_mvd), 0);
    check("a_midrst_bits", int'(a_bits), 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("a_no_done_after_reset", int'(a_done), 0);
    end
    setc(0, 3, 4); setc(1, 2, 2);
    e = '{1, 0, 1, 4};
    run_eval(0, 2, 3, e, 0, 1'b0);

    // Random evaluations against the reference model
    for (int t = 0; t < 1200; t++) begin
      int u, n;
      u = t % 2;
      n = (u == 0) ? 2 : 8;
      mx = int'($urandom_range(0, 1023)) - 512;
      my = int'($urandom_range(0, 1023)) - 512;
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 0) begin
          cand_x[i] = int'($urandom_range(0, 1023)) - 512;
          cand_y[i] = int'($urandom_range(0, 1023)) - 512;
        end else begin
          cand_x[i] = clipd(mx + int'($urandom_range(0, 8)) - 4, 10);
          cand_y[i] = clipd(my + int'($urandom_range(0, 8)) - 4, 10);
        end
      end
      e = model(u, mx, my);
      run_eval(u, mx, my, e, 2, 1'b0);
    end

    repeat (5) @(negedge clk);
    check("a_queue_empty", qa.size(), 0);
    check("b_queue_empty", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
